// File: rtl/sram_latency_fifo_ctrl.sv
// FIFO controller in front of a fixed-latency dual-port SRAM: pushes become SRAM writes,
// reads are issued ahead of demand, and returned data lands in a credit-managed pop buffer.
module sram_latency_fifo_ctrl #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned LATENCY   = 5,
   parameter int unsigned OUT_DEPTH = LATENCY + 2,
   parameter int unsigned ADDR_W    = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_vld_i,
   output logic              push_rdy_o,
   input  logic [WIDTH-1:0]  push_data_i,
   output logic              pop_vld_o,
   input  logic              pop_rdy_i,
   output logic [WIDTH-1:0]  pop_data_o,
   output logic              sram_wen_o,
   output logic [ADDR_W-1:0] sram_waddr_o,
   output logic [WIDTH-1:0]  sram_wdata_o,
   output logic              sram_ren_o,
   output logic [ADDR_W-1:0] sram_raddr_o,
   input  logic [WIDTH-1:0]  sram_rdata_i,
   input  logic              sram_vld_i
);

   localparam int unsigned SCNT_W = ADDR_W + 1;
   localparam int unsigned CNT_W  = $clog2(OUT_DEPTH + 1);
   localparam int unsigned BUF_AW = $clog2(OUT_DEPTH);

   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [SCNT_W-1:0] sram_cnt_q, sram_cnt_d;
   logic [CNT_W-1:0]  credit_q, credit_d;
   logic [CNT_W-1:0]  buf_cnt_q, buf_cnt_d;
   logic [BUF_AW-1:0] buf_wr_q, buf_wr_d;
   logic [BUF_AW-1:0] buf_rd_q, buf_rd_d;
   logic [WIDTH-1:0]  buf_mem_q [OUT_DEPTH];

   logic push_hs;
   logic issue;
   logic pop_hs;

   // The output buffer depth need not be a power of two, so wrap explicitly.
   function automatic logic [BUF_AW-1:0] buf_inc(input logic [BUF_AW-1:0] ptr);
      return (ptr == BUF_AW'(OUT_DEPTH - 1)) ? '0 : ptr + BUF_AW'(1);
   endfunction

   always_comb begin
      push_rdy_o   = !rst_i && (sram_cnt_q < SCNT_W'(DEPTH));
      push_hs      = push_vld_i && push_rdy_o;
      issue        = (sram_cnt_q != '0) && (credit_q < CNT_W'(OUT_DEPTH));
      pop_vld_o    = (buf_cnt_q != '0);
      pop_hs       = pop_vld_o && pop_rdy_i;
      sram_wen_o   = push_hs;
      sram_waddr_o = wptr_q;
      sram_wdata_o = push_data_i;
      sram_ren_o   = issue;
      sram_raddr_o = rptr_q;
      pop_data_o   = buf_mem_q[buf_rd_q];
   end

   always_comb begin
      wptr_d     = push_hs ? wptr_q + ADDR_W'(1) : wptr_q;
      rptr_d     = issue ? rptr_q + ADDR_W'(1) : rptr_q;
      buf_wr_d   = sram_vld_i ? buf_inc(buf_wr_q) : buf_wr_q;
      buf_rd_d   = pop_hs ? buf_inc(buf_rd_q) : buf_rd_q;
      sram_cnt_d = sram_cnt_q;
      credit_d   = credit_q;
      buf_cnt_d  = buf_cnt_q;
      if (push_hs && !issue) begin
         sram_cnt_d = sram_cnt_q + SCNT_W'(1);
      end else if (!push_hs && issue) begin
         sram_cnt_d = sram_cnt_q - SCNT_W'(1);
      end
      // Credits cover both reads in flight and buffered words, so a return moves
      // a credit between the two without changing the total.
      if (issue && !pop_hs) begin
         credit_d = credit_q + CNT_W'(1);
      end else if (!issue && pop_hs) begin
         credit_d = credit_q - CNT_W'(1);
      end
      if (sram_vld_i && !pop_hs) begin
         buf_cnt_d = buf_cnt_q + CNT_W'(1);
      end else if (!sram_vld_i && pop_hs) begin
         buf_cnt_d = buf_cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         sram_cnt_q <= '0;
         credit_q   <= '0;
         buf_cnt_q  <= '0;
         buf_wr_q   <= '0;
         buf_rd_q   <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         sram_cnt_q <= sram_cnt_d;
         credit_q   <= credit_d;
         buf_cnt_q  <= buf_cnt_d;
         buf_wr_q   <= buf_wr_d;
         buf_rd_q   <= buf_rd_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (sram_vld_i) begin
         buf_mem_q[buf_wr_q] <= sram_rdata_i;
      end
   end

`ifndef SYNTHESIS
   logic [CNT_W-1:0] inflight;
   assign inflight = credit_q - buf_cnt_q;

   a_vld_needs_read: assert property (@(posedge clk_i) disable iff (rst_i)
      sram_vld_i |-> (inflight != '0));
   a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      credit_q <= CNT_W'(OUT_DEPTH));
`endif

endmodule

// File: tb/tb_sram_latency_fifo_ctrl.sv
// Self-checking bench for sram_latency_fifo_ctrl with a behavioural fixed-latency SRAM
// and an event-count reference model (pushes, issues, returns, pops) plus a data scoreboard.
module tb_sram_latency_fifo_ctrl;
   localparam int unsigned WIDTH     = 8;
   localparam int unsigned DEPTH     = 8;
   localparam int unsigned LATENCY   = 5;
   localparam int unsigned OUT_DEPTH = LATENCY + 2;
   localparam int unsigned ADDR_W    = 3;

   logic              clk = 1'b0;
   logic              rst_i = 1'b1;
   logic              push_vld_i = 1'b0;
   logic              push_rdy_o;
   logic [WIDTH-1:0]  push_data_i = '0;
   logic              pop_vld_o;
   logic              pop_rdy_i = 1'b0;
   logic [WIDTH-1:0]  pop_data_o;
   logic              sram_wen_o;
   logic [ADDR_W-1:0] sram_waddr_o;
   logic [WIDTH-1:0]  sram_wdata_o;
   logic              sram_ren_o;
   logic [ADDR_W-1:0] sram_raddr_o;
   logic [WIDTH-1:0]  sram_rdata_i;
   logic              sram_vld_i;

   sram_latency_fifo_ctrl #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .LATENCY   (LATENCY),
      .OUT_DEPTH (OUT_DEPTH),
      .ADDR_W    (ADDR_W)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .push_vld_i   (push_vld_i),
      .push_rdy_o   (push_rdy_o),
      .push_data_i  (push_data_i),
      .pop_vld_o    (pop_vld_o),
      .pop_rdy_i    (pop_rdy_i),
      .pop_data_o   (pop_data_o),
      .sram_wen_o   (sram_wen_o),
      .sram_waddr_o (sram_waddr_o),
      .sram_wdata_o (sram_wdata_o),
      .sram_ren_o   (sram_ren_o),
      .sram_raddr_o (sram_raddr_o),
      .sram_rdata_i (sram_rdata_i),
      .sram_vld_i   (sram_vld_i)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: read data appears LATENCY cycles after ren, cleared by reset.
   logic [WIDTH-1:0]   mem [DEPTH];
   logic [LATENCY-1:0] vpipe = '0;
   logic [WIDTH-1:0]   dpipe [LATENCY];

   always @(posedge clk) begin
      if (sram_wen_o) mem[sram_waddr_o] <= sram_wdata_o;
      if (rst_i) vpipe <= '0;
      else vpipe <= {vpipe[LATENCY-2:0], sram_ren_o};
      dpipe[0] <= mem[sram_raddr_o];
      for (int i = 1; i < LATENCY; i++) dpipe[i] <= dpipe[i-1];
   end

   assign sram_vld_i   = vpipe[LATENCY-1];
   assign sram_rdata_i = dpipe[LATENCY-1];

   int n_cmp = 0;
   int n_fail = 0;
   int n_push, n_issue, n_ret, n_pop;
   logic [WIDTH-1:0] sb [$];

   task automatic clear_model();
      n_push = 0; n_issue = 0; n_ret = 0; n_pop = 0;
      sb.delete();
   endtask

   // Records what happened in the current cycle, then moves to the next negedge.
   task automatic tick();
      if (push_vld_i && push_rdy_o) begin
         sb.push_back(push_data_i);
         n_push++;
      end
      if (sram_ren_o) n_issue++;
      if (sram_vld_i) n_ret++;
      if (pop_vld_o && pop_rdy_i) begin
         n_pop++;
         if (sb.size() > 0) void'(sb.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_i = 1'b1; push_vld_i = 1'b0; pop_rdy_i = 1'b0;
      tick(); tick();
      rst_i = 1'b0;
      clear_model();
   endtask

   task automatic test_reset();
      rst_i = 1'b1; push_vld_i = 1'b1; push_data_i = 8'h11; pop_rdy_i = 1'b1; #1;
      n_cmp++; if (push_rdy_o !== 1'b0) begin n_fail++;
         $display("FAIL reset_push_rdy: got %b want 0", push_rdy_o); end
      n_cmp++; if (sram_wen_o !== 1'b0) begin n_fail++;
         $display("FAIL reset_wen: got %b want 0", sram_wen_o); end
      n_cmp++; if (sram_ren_o !== 1'b0) begin n_fail++;
         $display("FAIL reset_ren: got %b want 0", sram_ren_o); end
      n_cmp++; if (pop_vld_o !== 1'b0) begin n_fail++;
         $display("FAIL reset_pop_vld: got %b want 0", pop_vld_o); end
      tick();
      rst_i = 1'b0; push_vld_i = 1'b0; clear_model(); #1;
      n_cmp++; if (push_rdy_o !== 1'b1) begin n_fail++;
         $display("FAIL post_reset_push_rdy: got %b want 1", push_rdy_o); end
      n_cmp++; if (pop_vld_o !== 1'b0) begin n_fail++;
         $display("FAIL post_reset_pop_vld: got %b want 0", pop_vld_o); end
      tick();
   endtask

   task automatic test_single();
      logic exp;
      do_reset();
      pop_rdy_i = 1'b1;
      for (int c = 0; c < 12; c++) begin
         push_vld_i = (c == 0); push_data_i = 8'hA5; #1;
         if (c == 0) begin
            n_cmp++; if (sram_wen_o !== 1'b1 || sram_waddr_o !== 3'd0 || sram_wdata_o !== 8'hA5)
               begin n_fail++; $display("FAIL single_write: got wen=%b addr=%0d data=%h want 1/0/a5",
                  sram_wen_o, sram_waddr_o, sram_wdata_o); end
         end
         exp = (c == 1);
         n_cmp++; if (sram_ren_o !== exp) begin n_fail++;
            $display("FAIL single_ren c%0d: got %b want %b", c, sram_ren_o, exp); end
         if (c == 1) begin
            n_cmp++; if (sram_raddr_o !== 3'd0) begin n_fail++;
               $display("FAIL single_raddr: got %0d want 0", sram_raddr_o); end
         end
         exp = (c == 7);
         n_cmp++; if (pop_vld_o !== exp) begin n_fail++;
            $display("FAIL single_pop_vld c%0d: got %b want %b", c, pop_vld_o, exp); end
         if (c == 7) begin
            n_cmp++; if (pop_data_o !== 8'hA5) begin n_fail++;
               $display("FAIL single_pop_data: got %h want a5", pop_data_o); end
         end
         tick();
      end
   endtask

   task automatic test_stream();
      int sent = 0, got = 0, first = -1, last = -1, drops = 0;
      do_reset();
      pop_rdy_i = 1'b1;
      for (int c = 0; c < 150 && got < 64; c++) begin
         push_vld_i = (sent < 64); push_data_i = 8'(sent); #1;
         if (push_vld_i && !push_rdy_o) drops++;
         if (pop_vld_o) begin
            n_cmp++; if (pop_data_o !== 8'(got)) begin n_fail++;
               $display("FAIL stream_data #%0d: got %h want %h", got, pop_data_o, 8'(got)); end
            if (first < 0) first = c;
            last = c;
            got++;
         end
         if (push_vld_i && push_rdy_o) sent++;
         tick();
      end
      push_vld_i = 1'b0;
      n_cmp++; if (got != 64) begin n_fail++;
         $display("FAIL stream_count: got %0d want 64", got); end
      n_cmp++; if (drops != 0) begin n_fail++;
         $display("FAIL stream_push_rdy_drops: got %0d want 0", drops); end
      n_cmp++; if (last - first != 63) begin n_fail++;
         $display("FAIL stream_rate: got span %0d want 63", last - first); end
   endtask

   task automatic test_fill();
      int ren_seen = 0, got = 0;
      do_reset();
      pop_rdy_i = 1'b0;
      for (int c = 0; c < 30; c++) begin
         push_vld_i = 1'b1; push_data_i = 8'($urandom); #1;
         tick();
      end
      push_vld_i = 1'b0; #1;
      n_cmp++; if (n_push != 15) begin n_fail++;
         $display("FAIL fill_accepted: got %0d want 15", n_push); end
      n_cmp++; if (push_rdy_o !== 1'b0) begin n_fail++;
         $display("FAIL fill_push_rdy: got %b want 0", push_rdy_o); end
      n_cmp++; if (pop_vld_o !== 1'b1) begin n_fail++;
         $display("FAIL fill_pop_vld: got %b want 1", pop_vld_o); end
      for (int c = 0; c < 10; c++) begin
         if (sram_ren_o) ren_seen++;
         tick(); #1;
      end
      n_cmp++; if (ren_seen != 0) begin n_fail++;
         $display("FAIL fill_ren_idle: got %0d issues want 0", ren_seen); end
      tick();
      pop_rdy_i = 1'b1;
      for (int c = 0; c < 60 && sb.size() > 0; c++) begin
         #1;
         if (pop_vld_o) begin
            n_cmp++; if (pop_data_o !== sb[0]) begin n_fail++;
               $display("FAIL fill_drain #%0d: got %h want %h", got, pop_data_o, sb[0]); end
            got++;
         end
         tick();
      end
      #1;
      n_cmp++; if (got != 15 || pop_vld_o !== 1'b0) begin n_fail++;
         $display("FAIL fill_drain_end: got %0d words vld=%b want 15 words vld=0", got, pop_vld_o); end
      tick();
   endtask

   task automatic test_wrap();
      do_reset();
      pop_rdy_i = 1'b0;
      for (int c = 0; c < 14; c++) begin
         push_vld_i = 1'b1; push_data_i = 8'($urandom); #1;
         tick();
      end
      push_vld_i = 1'b0;
      for (int c = 0; c < 10; c++) begin #1; tick(); end
      // One pop frees a credit so the next cycle issues while a push lands at sram_cnt=7.
      pop_rdy_i = 1'b1; #1;
      n_cmp++; if (sram_ren_o !== 1'b0 || pop_vld_o !== 1'b1 || pop_data_o !== sb[0]) begin
         n_fail++; $display("FAIL wrap_pre: got ren=%b vld=%b data=%h want 0/1/%h",
            sram_ren_o, pop_vld_o, pop_data_o, sb[0]); end
      tick();
      pop_rdy_i = 1'b0; push_vld_i = 1'b1; push_data_i = 8'h5A; #1;
      n_cmp++; if (push_rdy_o !== 1'b1 || sram_ren_o !== 1'b1) begin n_fail++;
         $display("FAIL wrap_simul: got rdy=%b ren=%b want 1/1", push_rdy_o, sram_ren_o); end
      n_cmp++; if (sram_waddr_o !== 3'd6 || sram_raddr_o !== 3'd7) begin n_fail++;
         $display("FAIL wrap_addr: got w=%0d r=%0d want 6/7", sram_waddr_o, sram_raddr_o); end
      tick();
      push_data_i = 8'hC3; #1;
      n_cmp++; if (push_rdy_o !== 1'b1 || sram_ren_o !== 1'b0 || sram_waddr_o !== 3'd7) begin
         n_fail++; $display("FAIL wrap_after: got rdy=%b ren=%b w=%0d want 1/0/7",
            push_rdy_o, sram_ren_o, sram_waddr_o); end
      tick();
      push_vld_i = 1'b0; #1;
      n_cmp++; if (push_rdy_o !== 1'b0) begin n_fail++;
         $display("FAIL wrap_full: got %b want 0", push_rdy_o); end
      tick();
      pop_rdy_i = 1'b1;
      for (int c = 0; c < 60 && sb.size() > 0; c++) begin
         #1;
         if (sram_ren_o) begin
            n_cmp++; if (sram_raddr_o !== ADDR_W'(n_issue % DEPTH)) begin n_fail++;
               $display("FAIL wrap_raddr: got %0d want %0d", sram_raddr_o, n_issue % DEPTH); end
         end
         if (pop_vld_o) begin
            n_cmp++; if (pop_data_o !== sb[0]) begin n_fail++;
               $display("FAIL wrap_drain: got %h want %h", pop_data_o, sb[0]); end
         end
         tick();
      end
      n_cmp++; if (sb.size() != 0 || n_pop != 16) begin n_fail++;
         $display("FAIL wrap_total: got %0d pops %0d left want 16/0", n_pop, sb.size()); end
   endtask

   task automatic test_random();
      logic exp_rdy, exp_ren, exp_pv;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         push_vld_i  = ($urandom_range(0, 99) < 55);
         push_data_i = 8'($urandom);
         pop_rdy_i   = (c < 750) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 80);
         #1;
         exp_rdy = (n_push - n_issue) < int'(DEPTH);
         exp_ren = (n_push != n_issue) && ((n_issue - n_pop) < int'(OUT_DEPTH));
         exp_pv  = (n_ret - n_pop) > 0;
         n_cmp++; if (push_rdy_o !== exp_rdy) begin n_fail++;
            $display("FAIL rand_push_rdy c%0d: got %b want %b", c, push_rdy_o, exp_rdy); end
         n_cmp++; if (sram_ren_o !== exp_ren) begin n_fail++;
            $display("FAIL rand_ren c%0d: got %b want %b", c, sram_ren_o, exp_ren); end
         n_cmp++; if (pop_vld_o !== exp_pv) begin n_fail++;
            $display("FAIL rand_pop_vld c%0d: got %b want %b", c, pop_vld_o, exp_pv); end
         n_cmp++; if (sram_wen_o !== (push_vld_i && exp_rdy)) begin n_fail++;
            $display("FAIL rand_wen c%0d: got %b want %b", c, sram_wen_o, push_vld_i && exp_rdy); end
         if (sram_wen_o) begin
            n_cmp++; if (sram_waddr_o !== ADDR_W'(n_push % DEPTH)) begin n_fail++;
               $display("FAIL rand_waddr c%0d: got %0d want %0d", c, sram_waddr_o, n_push % DEPTH); end
         end
         if (sram_ren_o) begin
            n_cmp++; if (sram_raddr_o !== ADDR_W'(n_issue % DEPTH)) begin n_fail++;
               $display("FAIL rand_raddr c%0d: got %0d want %0d", c, sram_raddr_o, n_issue % DEPTH); end
         end
         if (pop_vld_o && sb.size() > 0) begin
            n_cmp++; if (pop_data_o !== sb[0]) begin n_fail++;
               $display("FAIL rand_pop_data c%0d: got %h want %h", c, pop_data_o, sb[0]); end
         end
         if (sram_vld_i) begin
            n_cmp++; if (n_issue <= n_ret) begin n_fail++;
               $display("FAIL rand_vld_no_read c%0d: got %0d issued want > %0d", c, n_issue, n_ret); end
         end
         n_cmp++; if (n_issue - n_pop > int'(OUT_DEPTH)) begin n_fail++;
            $display("FAIL rand_credit c%0d: got %0d want <= %0d", c, n_issue - n_pop, OUT_DEPTH); end
         tick();
      end
      push_vld_i = 1'b0; pop_rdy_i = 1'b1;
      for (int c = 0; c < 80 && sb.size() > 0; c++) begin
         #1;
         if (pop_vld_o) begin
            n_cmp++; if (pop_data_o !== sb[0]) begin n_fail++;
               $display("FAIL rand_drain: got %h want %h", pop_data_o, sb[0]); end
         end
         tick();
      end
      n_cmp++; if (sb.size() != 0) begin n_fail++;
         $display("FAIL rand_leftover: got %0d words want 0", sb.size()); end
   endtask

   task automatic test_reset_mid();
      int found = 0, noise = 0;
      logic exp;
      do_reset();
      pop_rdy_i = 1'b0;
      for (int c = 0; c < 25; c++) begin
         if ((n_ret - n_pop) == 4 && (n_issue - n_ret) == 3) begin found = 1; break; end
         push_vld_i = 1'b1; push_data_i = 8'($urandom); #1;
         tick();
      end
      n_cmp++; if (found != 1) begin n_fail++;
         $display("FAIL rmid_setup: got buffered=%0d inflight=%0d want 4/3",
            n_ret - n_pop, n_issue - n_ret); end
      rst_i = 1'b1; push_vld_i = 1'b1; #1;
      n_cmp++; if (push_rdy_o !== 1'b0 || sram_wen_o !== 1'b0) begin n_fail++;
         $display("FAIL rmid_in_reset: got rdy=%b wen=%b want 0/0", push_rdy_o, sram_wen_o); end
      tick();
      rst_i = 1'b0; push_vld_i = 1'b0; clear_model(); #1;
      n_cmp++; if (pop_vld_o !== 1'b0 || sram_ren_o !== 1'b0 || sram_wen_o !== 1'b0) begin
         n_fail++; $display("FAIL rmid_after: got vld=%b ren=%b wen=%b want 0/0/0",
            pop_vld_o, sram_ren_o, sram_wen_o); end
      n_cmp++; if (push_rdy_o !== 1'b1) begin n_fail++;
         $display("FAIL rmid_push_rdy: got %b want 1", push_rdy_o); end
      for (int c = 0; c < 8; c++) begin
         tick(); #1;
         if (sram_vld_i || pop_vld_o || sram_ren_o) noise++;
      end
      n_cmp++; if (noise != 0) begin n_fail++;
         $display("FAIL rmid_stale: got %0d active cycles want 0", noise); end
      tick();
      pop_rdy_i = 1'b1;
      for (int c = 0; c < 12; c++) begin
         push_vld_i = (c == 0); push_data_i = 8'h3C; #1;
         exp = (c == 7);
         n_cmp++; if (pop_vld_o !== exp) begin n_fail++;
            $display("FAIL rmid_new_vld c%0d: got %b want %b", c, pop_vld_o, exp); end
         if (c == 7) begin
            n_cmp++; if (pop_data_o !== 8'h3C) begin n_fail++;
               $display("FAIL rmid_new_data: got %h want 3c", pop_data_o); end
         end
         tick();
      end
   endtask

   initial begin
      clear_model();
      @(negedge clk);
      test_reset();
      test_single();
      test_stream();
      test_fill();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
